tlul_host_initiator: RTL
========================

// Module: tlul_host_initiator
// PURPOSE
//  TL-UL host (initiator) end of the bus: turns a simple req/gnt/valid core port into TL-UL A-channel
//  requests and retires D-channel responses. Sits between a master (DMA, debug, test sequencer) and the
//  crossbar/device side. Widths come from top_pkg (TL_AW=32, TL_DW=32, TL_AIW=8, TL_SZW=2).
//  Tracks up to MAX_REQS outstanding transactions with an in-order source-ID queue.
// PARAMETERS
//  MAX_REQS  2  max outstanding A requests; power of two, 1..16; source IDs 0..MAX_REQS-1
// PORTS
//  clk_i        in   1       clock
//  rst_i        in   1       async reset, active-high
//  req_i        in   1       core request
//  gnt_o        out  1       request accepted this cycle
//  we_i         in   1       1=write, 0=read
//  addr_i       in   TL_AW   byte address; [1:0] forwarded unchanged
//  wdata_i      in   TL_DW   write data
//  be_i         in   TL_DBW  byte enables
//  valid_o      out  1       response valid (one-cycle pulse)
//  rdata_o      out  TL_DW   read data; 0 for write responses
//  err_o        out  1       response error, qualified by valid_o
//  err_sticky_o out  1       latched protocol error, cleared only by reset
//  a_valid_o    out  1       A valid
//  a_opcode_o   out  3       A opcode: Get=4, PutFullData=0, PutPartialData=1
//  a_size_o     out  TL_SZW  constant 2
//  a_source_o   out  TL_AIW  source ID
//  a_address_o  out  TL_AW   A address
//  a_mask_o     out  TL_DBW  A mask
//  a_data_o     out  TL_DW   A data
//  a_ready_i    in   1       A ready
//  d_valid_i    in   1       D valid
//  d_opcode_i   in   3       AccessAck=0, AccessAckData=1
//  d_source_i   in   TL_AIW  D source
//  d_data_i     in   TL_DW   D data
//  d_error_i    in   1       D error
//  d_ready_o    out  1       constant 1; host always sinks responses
// BEHAVIOUR
//  - Reset: all outputs 0 except d_ready_o=1 and a_size_o=2; outstanding count=0, src ptr=0,
//    ID queue empty, err_sticky_o=0.
//  - A path is combinational, 0 cycles: a_valid_o = req_i & ~full.
//    Address/data/mask pass straight from the core port.
//  - a_opcode_o: read -> Get, mask=be_i. Write with be_i all-ones -> PutFullData.
//    Write otherwise -> PutPartialData.
//  - gnt_o = a_valid_o & a_ready_i. On grant:
//    - a_source_o (= src ptr) is pushed into the ID queue.
//    - src ptr increments mod MAX_REQS.
//    - count++.
//  - full = (count==MAX_REQS). When full, a_valid_o=0 and gnt_o=0 regardless of a_ready_i.
//    a_valid_o may drop only because the core drops req_i; the core must hold req_i and the
//    request fields until gnt_o.
//  - D path: a beat is accepted whenever d_valid_i=1 (d_ready_o=1). On acceptance with count>0:
//    - pop the queue, count--.
//    - Next cycle: valid_o=1; rdata_o=d_data_i if d_opcode_i==AccessAckData, else 0;
//      err_o=d_error_i | local check errors. Response latency is 1 cycle, registered.
//  - D beat with count==0 (unexpected): dropped, no valid_o, err_sticky_o<=1.
//  - Illegal d_opcode_i (not 0 or 1): response still retired; err_o=1, err_sticky_o<=1.
//  - Grant and D retire in the same cycle: count unchanged; push and pop both occur; legal when full.
//  - Count saturates by construction; queue depth = MAX_REQS.
//  - Reset mid-transaction: all tracking discarded. Later D beats for pre-reset IDs are treated
//    as unexpected and set err_sticky_o.
// CONFIGURATION
//  TLUL_HOST_SRC_CHECK_EN defined:
//    - d_source_i is compared with the queue head on every retired beat.
//    - Mismatch -> err_o=1 on that response and err_sticky_o<=1. The beat is still retired and popped.
//  Undefined:
//    - No comparison; d_source_i is ignored; the queue holds only the count, not IDs.
//    - Mismatch never raises an error.
// TESTING
//  1 Read: req_i=1,we_i=0,addr_i=0x40, a_ready_i=1 -> same cycle gnt_o=1,a_opcode_o=4,a_source_o=0;
//    D AccessAckData data=0xDEADBEEF -> next cycle valid_o=1,rdata_o=0xDEADBEEF,err_o=0.
//  2 Writes: be_i=0xF -> opcode 0, mask 0xF; be_i=0x3 -> opcode 1, mask 0x3.
//    AccessAck -> valid_o=1, rdata_o=0.
//  3 Full: MAX_REQS=2, three back-to-back reqs, no D -> reqs 1,2 granted with sources 0,1.
//    Third: a_valid_o=0 and gnt_o=0 until a D beat retires, then granted with source 0.
//  4 Same-cycle grant and retire at count=2 -> count stays 2, no lost response, sources rotate correctly.
//  5 Errors:
//    - d_error_i=1 -> err_o=1 with valid_o, err_sticky_o stays 0.
//    - D beat at count=0 -> no valid_o, err_sticky_o=1.
//    - d_opcode_i=2 -> err_o=1, err_sticky_o=1.
//  6 Source check: send source 0 outstanding, D returns source 1.
//    Macro defined -> err_o=1, err_sticky_o=1. Undefined -> err_o=0.
//    Then assert rst_i mid-transaction -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/tlul_host_initiator.sv
// TL-UL host initiator: core req/gnt/valid port to TL-UL A/D channels, up to MAX_REQS in flight.
// Optional build macro TLUL_HOST_SRC_CHECK_EN adds a D-source vs. ID-queue-head check.
module tlul_host_initiator #(
   parameter  int MAX_REQS = 2,
   localparam int TL_AW    = 32,
   localparam int TL_DW    = 32,
   localparam int TL_AIW   = 8,
   localparam int TL_SZW   = 2,
   localparam int TL_DBW   = TL_DW / 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic              we_i,
   input  logic [TL_AW-1:0]  addr_i,
   input  logic [TL_DW-1:0]  wdata_i,
   input  logic [TL_DBW-1:0] be_i,
   output logic              valid_o,
   output logic [TL_DW-1:0]  rdata_o,
   output logic              err_o,
   output logic              err_sticky_o,
   output logic              a_valid_o,
   output logic [2:0]        a_opcode_o,
   output logic [TL_SZW-1:0] a_size_o,
   output logic [TL_AIW-1:0] a_source_o,
   output logic [TL_AW-1:0]  a_address_o,
   output logic [TL_DBW-1:0] a_mask_o,
   output logic [TL_DW-1:0]  a_data_o,
   input  logic              a_ready_i,
   input  logic              d_valid_i,
   input  logic [2:0]        d_opcode_i,
   input  logic [TL_AIW-1:0] d_source_i,
   input  logic [TL_DW-1:0]  d_data_i,
   input  logic              d_error_i,
   output logic              d_ready_o
);

   localparam int PTR_W = (MAX_REQS > 1) ? $clog2(MAX_REQS) : 1;
   localparam int CNT_W = $clog2(MAX_REQS + 1);

   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] D_ACK          = 3'd0;
   localparam logic [2:0] D_ACK_DATA     = 3'd1;

   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] src_ptr_q;
   logic             full;
   logic             d_retire;
   logic             d_unexpected;
   logic             d_illegal;
   logic             src_mismatch;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_REQS - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full = (count_q == CNT_W'(MAX_REQS));

   // A request is withheld while reset is asserted so the bus sees no valid during reset.
   assign a_valid_o   = req_i & ~full & ~rst_i;
   assign gnt_o       = a_valid_o & a_ready_i;
   assign a_opcode_o  = ~we_i ? OP_GET : ((&be_i) ? OP_PUT_FULL : OP_PUT_PARTIAL);
   assign a_size_o    = TL_SZW'(2);
   assign a_source_o  = TL_AIW'(src_ptr_q);
   assign a_address_o = addr_i;
   assign a_mask_o    = be_i;
   assign a_data_o    = wdata_i;
   assign d_ready_o   = 1'b1;

   assign d_retire     = d_valid_i & (count_q != '0);
   assign d_unexpected = d_valid_i & (count_q == '0);
   assign d_illegal    = (d_opcode_i != D_ACK) && (d_opcode_i != D_ACK_DATA);

`ifdef TLUL_HOST_SRC_CHECK_EN
   logic [TL_AIW-1:0] id_q [MAX_REQS];
   logic [PTR_W-1:0]  rd_ptr_q;

   // Write slot always equals src_ptr_q because both advance together on every grant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         for (int i = 0; i < MAX_REQS; i++) begin
            id_q[i] <= '0;
         end
      end else begin
         if (gnt_o) begin
            id_q[src_ptr_q] <= a_source_o;
         end
         if (d_retire) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
      end
   end

   assign src_mismatch = (d_source_i != id_q[rd_ptr_q]);
`else
   logic unused_d_source;
   assign unused_d_source = ^d_source_i;
   assign src_mismatch    = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q      <= '0;
         src_ptr_q    <= '0;
         valid_o      <= 1'b0;
         rdata_o      <= '0;
         err_o        <= 1'b0;
         err_sticky_o <= 1'b0;
      end else begin
         if (gnt_o) begin
            src_ptr_q <= ptr_inc(src_ptr_q);
         end
         case ({gnt_o, d_retire})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         valid_o <= d_retire;
         rdata_o <= (d_retire && (d_opcode_i == D_ACK_DATA)) ? d_data_i : '0;
         err_o   <= d_retire & (d_error_i | d_illegal | src_mismatch);
         if (d_unexpected || (d_retire && (d_illegal || src_mismatch))) begin
            err_sticky_o <= 1'b1;
         end
      end
   end

endmodule
